// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared types and helpers for the oversampling UART receiver: |
// |               receiver state encoding, baud divider computation and the    |
// |               three mid-bit sample tick indices derived from OVERSAMPLE.   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  // Number of data bits per frame.
  localparam int DATA_BITS = 8;

  // Receiver states, explicitly 3 bits wide.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Clocks per sample tick. Integer division may round to zero when the
  // clock is too slow for the requested rate; a divider of one is used then.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

  // Tick indices (0-based within a bit) of the three majority-vote samples.
  function automatic int smp_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int smp_mid(input int os);
    return os / 2;
  endfunction

  function automatic int smp_hi(input int os);
    return os / 2 + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_baud_tick                                               |
// | Description : Sample tick generator. Emits a one-clk tick every DIV clks.  |
// |               A restart pulse clears the divider so the first tick after   |
// |               it lands DIV clks later, aligning ticks to a start edge.     |
// | Ports       : clk     - clock, rising edge                                 |
// |               rst     - synchronous active-low reset                       |
// |               restart - clear the divider phase                            |
// |               tick    - one-clk sample tick                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_W'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/uart_rx_os.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_os                                                   |
// | Description : Oversampling UART receiver, 8 data bits LSB first, one stop  |
// |               bit, optional even parity. Each bit is decided by a 2-of-3   |
// |               majority of samples taken around mid-bit.                    |
// | Config      : define UART_RX_PARITY_EN to receive 8E1 frames; without it   |
// |               frames are 8N1 and parity_err is constant 0.                 |
// | Ports       : clk        - clock, rising edge                              |
// |               rst        - synchronous active-low reset                    |
// |               rx         - asynchronous serial line, idle high             |
// |               rxdata     - last received byte                              |
// |               done       - one-clk pulse when a frame completes            |
// |               frame_err  - stop bit sampled low (valid with done)          |
// |               parity_err - parity mismatch (valid with done)               |
// |               busy       - receiver is not idle                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV     = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CNT_W   = $clog2(OVERSAMPLE);
  localparam int SMP_LO  = smp_lo(OVERSAMPLE);
  localparam int SMP_MID = smp_mid(OVERSAMPLE);
  localparam int SMP_HI  = smp_hi(OVERSAMPLE);

  if ((OVERSAMPLE < 8) || (OVERSAMPLE > 32) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
    $error("uart_rx_os: OVERSAMPLE must be an even value in 8..32");
  end

  // Line synchronizer and edge detection
  logic       r_sync1;
  logic       r_sync2;
  logic       r_rx_prev;
  logic [1:0] r_settle;
  logic       w_fall;

  // The synchronizer flops come out of reset preset high, so for the first
  // few clks they do not reflect the line. Edges are only honoured once both
  // r_sync2 and r_rx_prev hold genuine line samples; this keeps a line that
  // is already low at reset release from looking like a start edge.
  assign w_fall = (r_settle == 2'd3) && r_rx_prev && !r_sync2;

  // FSM and datapath
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic             w_tick;
  logic             w_restart;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [1:0]       r_votes;
  logic             w_maj;
  logic             w_decide;
  logic             w_bit_end;
  logic             w_frame_done;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rxdata;
  logic             r_done;
  logic             r_frame_err;

  assign w_restart = (r_state == ST_IDLE) && w_fall;
  assign w_decide  = w_tick && (r_smp_cnt == CNT_W'(SMP_HI));
  assign w_bit_end = w_tick && (r_smp_cnt == CNT_W'(OVERSAMPLE - 1));

  // 2-of-3 vote: two stored samples plus the live one at the last sample tick.
  assign w_maj = (r_votes[0] & r_votes[1]) |
                 (r_votes[0] & r_sync2)    |
                 (r_votes[1] & r_sync2);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (w_decide && w_maj) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a start bit immediately following the stop
        // bit finds the receiver already idle.
        if (w_decide) begin
          w_state_nxt  = ST_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_settle    <= 2'd0;
      r_smp_cnt   <= '0;
      r_votes     <= 2'b00;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rxdata    <= 8'h00;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      if (r_settle != 2'd3) begin
        r_settle <= r_settle + 2'd1;
      end

      if (w_restart) begin
        r_smp_cnt <= '0;
      end else if (w_tick && (r_state != ST_IDLE)) begin
        if (r_smp_cnt == CNT_W'(OVERSAMPLE - 1)) begin
          r_smp_cnt <= '0;
        end else begin
          r_smp_cnt <= r_smp_cnt + 1'b1;
        end
      end

      if (w_tick && (r_smp_cnt == CNT_W'(SMP_LO))) begin
        r_votes[0] <= r_sync2;
      end
      if (w_tick && (r_smp_cnt == CNT_W'(SMP_MID))) begin
        r_votes[1] <= r_sync2;
      end

      if ((r_state == ST_DATA) && w_decide) begin
        r_shift <= {w_maj, r_shift[7:1]};
      end

      if (w_restart) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == ST_DATA) && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      r_done <= w_frame_done;
      if (w_frame_done) begin
        r_rxdata    <= r_shift;
        r_frame_err <= ~w_maj;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if ((r_state == ST_PARITY) && w_decide) begin
        r_par_bit <= w_maj;
      end
      // Even parity: the data bits plus parity bit must hold an even count of ones.
      if (w_frame_done) begin
        r_parity_err <= (^r_shift) ^ r_par_bit;
      end
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rxdata    = r_rxdata;
  assign done      = r_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
